// File: rtl/tx_punc_pkg.sv
// Shared rate encodings, phase moduli and rate normalisation for tx_puncture.
// Optional feature: define TX_PUNC_RATE34_EN to enable the rate 3/4 puncturing path.
package tx_punc_pkg;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10
  } punc_rate_e;

  localparam int unsigned PHASE_MOD_2_3 = 4;
  localparam int unsigned PHASE_MOD_3_4 = 3;

  // Reserved code 11 (and 10 when the 3/4 path is built out) falls back to 1/2.
  function automatic punc_rate_e norm_rate(input logic [1:0] rate);
    case (rate)
      2'b01:   norm_rate = RATE_2_3;
`ifdef TX_PUNC_RATE34_EN
      2'b10:   norm_rate = RATE_3_4;
`endif
      default: norm_rate = RATE_1_2;
    endcase
  endfunction

endpackage

// File: rtl/tx_puncture.sv
// Puncturer for convolutionally coded {A,B} pairs at rates 1/2, 2/3 and 3/4.
// Optional feature: define TX_PUNC_RATE34_EN to enable the rate 3/4 path.
module tx_puncture
  import tx_punc_pkg::*;
#(
  parameter logic PAD_BIT = 1'b0
) (
  input  logic       clk_Modulation,
  input  logic       reset_n,
  input  logic       tx_conv_valid,
  input  logic [1:0] tx_conv_bit,
  input  logic [1:0] tx_punc_rate,
  output logic       tx_punc_valid,
  output logic [1:0] tx_punc_bit,
  output logic       tx_punc_pad
);

  logic       r_valid_d;
  punc_rate_e r_rate;
  logic [1:0] r_phase;
  logic       r_res;
  logic       r_res_vld;

  logic       w_start;
  logic       w_end;
  punc_rate_e w_rate;
  logic [1:0] w_phase;
  logic [1:0] w_phase_nxt;
  logic       w_res_nxt;
  logic       w_res_vld_nxt;
  logic       w_out_vld;
  logic [1:0] w_out_bit;
  logic       w_out_pad;
  logic       w_a;
  logic       w_b;

  assign w_a     = tx_conv_bit[1];
  assign w_b     = tx_conv_bit[0];
  assign w_start = tx_conv_valid & ~r_valid_d;
  assign w_end   = ~tx_conv_valid & r_valid_d;
  // The start pair is always P0 and already uses the rate being latched.
  assign w_rate  = w_start ? norm_rate(tx_punc_rate) : r_rate;
  assign w_phase = w_start ? 2'd0 : r_phase;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    w_phase_nxt   = r_phase;
    w_res_nxt     = r_res;
    w_res_vld_nxt = r_res_vld;
    w_out_vld     = 1'b0;
    w_out_bit     = tx_punc_bit;
    w_out_pad     = 1'b0;

    if (tx_conv_valid) begin
      w_res_vld_nxt = 1'b0;
      case (w_rate)
        RATE_2_3: begin
          w_phase_nxt = (w_phase == 2'(PHASE_MOD_2_3 - 1)) ? 2'd0 : w_phase + 2'd1;
          case (w_phase)
            2'd0: begin
              w_out_vld = 1'b1;
              w_out_bit = {w_a, w_b};
            end
            2'd1: begin
              w_res_nxt     = w_a;
              w_res_vld_nxt = 1'b1;
            end
            2'd2: begin
              w_out_vld     = 1'b1;
              w_out_bit     = {r_res, w_a};
              w_res_nxt     = w_b;
              w_res_vld_nxt = 1'b1;
            end
            default: begin
              w_out_vld = 1'b1;
              w_out_bit = {r_res, w_a};
            end
          endcase
        end
`ifdef TX_PUNC_RATE34_EN
        RATE_3_4: begin
          w_phase_nxt = (w_phase == 2'(PHASE_MOD_3_4 - 1)) ? 2'd0 : w_phase + 2'd1;
          case (w_phase)
            2'd0: begin
              w_out_vld = 1'b1;
              w_out_bit = {w_a, w_b};
            end
            2'd1: begin
              w_res_nxt     = w_a;
              w_res_vld_nxt = 1'b1;
            end
            default: begin
              w_out_vld = 1'b1;
              w_out_bit = {r_res, w_b};
            end
          endcase
        end
`endif
        default: begin
          w_phase_nxt = 2'd0;
          w_out_vld   = 1'b1;
          w_out_bit   = {w_a, w_b};
        end
      endcase
    end else if (w_end) begin
      // A half-filled word left at frame end goes out padded.
      if (r_res_vld) begin
        w_out_vld = 1'b1;
        w_out_bit = {r_res, PAD_BIT};
        w_out_pad = 1'b1;
      end
      w_phase_nxt   = 2'd0;
      w_res_nxt     = 1'b0;
      w_res_vld_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and clears on the async reset.
  always_ff @(posedge clk_Modulation or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_d     <= 1'b0;
      r_rate        <= RATE_1_2;
      r_phase       <= 2'd0;
      r_res         <= 1'b0;
      r_res_vld     <= 1'b0;
      tx_punc_valid <= 1'b0;
      tx_punc_bit   <= 2'b00;
      tx_punc_pad   <= 1'b0;
    end else begin
      r_valid_d     <= tx_conv_valid;
      r_rate        <= w_rate;
      r_phase       <= w_phase_nxt;
      r_res         <= w_res_nxt;
      r_res_vld     <= w_res_vld_nxt;
      tx_punc_valid <= w_out_vld;
      tx_punc_bit   <= w_out_bit;
      tx_punc_pad   <= w_out_pad;
    end
  end

endmodule
